// File: rtl/alu_arbiter_if.sv
// Bundle of requester handshakes, responses and shared-ALU drive for alu_arbiter.
// The slave modport is the arbiter side; master is the requesters plus the shared ALU.
interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req_valid0;
    logic             req_valid1;
    logic             req_ready0;
    logic             req_ready1;
    logic [3:0]       req_ctl0;
    logic [3:0]       req_ctl1;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b0;
    logic [WIDTH-1:0] req_b1;

    logic             rsp_valid0;
    logic             rsp_valid1;
    logic             rsp_ready0;
    logic             rsp_ready1;
    logic [WIDTH-1:0] rsp_data0;
    logic [WIDTH-1:0] rsp_data1;
    logic             rsp_zero0;
    logic             rsp_zero1;

    logic [3:0]       alu_ctl;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_out;
    logic             alu_zero;

    logic             busy;

    modport slave (
        input  req_valid0, req_valid1, req_ctl0, req_ctl1,
               req_a0, req_a1, req_b0, req_b1,
               rsp_ready0, rsp_ready1, alu_out, alu_zero,
        output req_ready0, req_ready1, rsp_valid0, rsp_valid1,
               rsp_data0, rsp_data1, rsp_zero0, rsp_zero1,
               alu_ctl, alu_a, alu_b, busy
    );

    modport master (
        output req_valid0, req_valid1, req_ctl0, req_ctl1,
               req_a0, req_a1, req_b0, req_b1,
               rsp_ready0, rsp_ready1, alu_out, alu_zero,
        input  req_ready0, req_ready1, rsp_valid0, rsp_valid1,
               rsp_data0, rsp_data1, rsp_zero0, rsp_zero1,
               alu_ctl, alu_a, alu_b, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU, one op in flight.
// Define ALU_ARB_RR_EN for round-robin on contention; otherwise requester 0 always wins.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rstn,
    alu_arbiter_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [3:0]       ctl_q, ctl_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             id_q, id_d;

    logic             grant_any;
    logic             grant_id;
    logic             rsp_fire;
    logic             rsp_sel0;
    logic             rsp_sel1;

`ifdef ALU_ARB_RR_EN
    logic             last_q, last_d;
`endif

    // A lone requester always wins; only contention consults the priority rule.
    always_comb begin
        grant_id = 1'b0;
        if (bus.req_valid0 && bus.req_valid1) begin
`ifdef ALU_ARB_RR_EN
            grant_id = ~last_q;
`else
            grant_id = 1'b0;
`endif
        end else if (bus.req_valid1) begin
            grant_id = 1'b1;
        end
    end

    // rstn gates the grant so req_ready drops the moment reset asserts.
    assign grant_any      = rstn && (state_q == ST_IDLE) && (bus.req_valid0 || bus.req_valid1);
    assign bus.req_ready0 = grant_any && !grant_id;
    assign bus.req_ready1 = grant_any &&  grant_id;

    assign rsp_sel0 = (state_q == ST_RESP) && !id_q;
    assign rsp_sel1 = (state_q == ST_RESP) &&  id_q;
    assign rsp_fire = (rsp_sel0 && bus.rsp_ready0) || (rsp_sel1 && bus.rsp_ready1);

    always_comb begin
        // NOTE: every _d defaults to its _q first so no path through the case infers a latch.
        state_d = state_q;
        ctl_d   = ctl_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        zero_d  = zero_q;
        id_d    = id_q;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    id_d    = grant_id;
                    ctl_d   = grant_id ? bus.req_ctl1 : bus.req_ctl0;
                    a_d     = grant_id ? bus.req_a1   : bus.req_a0;
                    b_d     = grant_id ? bus.req_b1   : bus.req_b0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_d   = bus.alu_out;
                zero_d  = bus.alu_zero;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_fire) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef ALU_ARB_RR_EN
    assign last_d = grant_any ? grant_id : last_q;

    // Reset as "last granted = 1" so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rstn) begin
            state_q <= ST_IDLE;
            ctl_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ctl_q   <= ctl_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            id_q    <= id_d;
        end
    end

    // The ALU sees only the latched operands, so they stay stable until the next grant.
    assign bus.alu_ctl = ctl_q;
    assign bus.alu_a   = a_q;
    assign bus.alu_b   = b_q;

    assign bus.rsp_valid0 = rsp_sel0;
    assign bus.rsp_valid1 = rsp_sel1;
    assign bus.rsp_data0  = rsp_sel0 ? res_q : '0;
    assign bus.rsp_data1  = rsp_sel1 ? res_q : '0;
    assign bus.rsp_zero0  = rsp_sel0 && zero_q;
    assign bus.rsp_zero1  = rsp_sel1 && zero_q;

    assign bus.busy = (state_q != ST_IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized bench for alu_arbiter with a behavioural ALU and a
// transaction-level reference model; honours ALU_ARB_RR_EN when defined.
module tb_alu_arbiter;
    localparam int WIDTH = 32;
`ifdef ALU_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(WIDTH)) bus ();
    alu_arbiter #(.WIDTH(WIDTH)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    int vectors     = 0;
    int miscompares = 0;

    function automatic logic [31:0] alu_ref(input logic [3:0] ctl, input logic [31:0] a,
                                            input logic [31:0] b);
        case (ctl)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd3:    return a ^ b;
            4'd4:    return b << a[4:0];
            4'd5:    return b >> a[4:0];
            4'd6:    return a - b;
            4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8:    return $unsigned($signed(b) >>> a[4:0]);
            4'd10:   return {b[15:0], 16'h0000};
            4'd12:   return ~(a | b);
            default: return a ^ {28'h5A5A000, ctl};
        endcase
    endfunction

    // Shared ALU lives in the bench environment.
    assign bus.alu_out  = alu_ref(bus.alu_ctl, bus.alu_a, bus.alu_b);
    assign bus.alu_zero = (bus.alu_out == '0);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit id, input logic v, input logic [3:0] ctl,
                           input logic [31:0] a, input logic [31:0] b);
        if (id) begin
            bus.req_valid1 = v; bus.req_ctl1 = ctl; bus.req_a1 = a; bus.req_b1 = b;
        end else begin
            bus.req_valid0 = v; bus.req_ctl0 = ctl; bus.req_a0 = a; bus.req_b0 = b;
        end
    endtask

    task automatic clear_inputs();
        set_req(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        set_req(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
        bus.rsp_ready0 = 1'b0;
        bus.rsp_ready1 = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    // Single-requester op with rsp_ready held; checks handshake, latency and result.
    task automatic run_op(input string tag, input bit id, input logic [3:0] ctl,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        set_req(id, 1'b1, ctl, a, b);
        if (id) bus.rsp_ready1 = 1'b1; else bus.rsp_ready0 = 1'b1;
        #1;
        check({tag, "_ready0"}, bus.req_ready0, !id);
        check({tag, "_ready1"}, bus.req_ready1, id);
        tick();
        set_req(id, 1'b0, 4'd0, 32'd0, 32'd0);
        check({tag, "_exec_busy"}, bus.busy, 1'b1);
        check({tag, "_exec_noready"}, bus.req_ready0 | bus.req_ready1, 1'b0);
        check({tag, "_alu_ctl"}, bus.alu_ctl, ctl);
        check({tag, "_exec_novalid"}, bus.rsp_valid0 | bus.rsp_valid1, 1'b0);
        tick();
        check({tag, "_rsp_valid0"}, bus.rsp_valid0, !id);
        check({tag, "_rsp_valid1"}, bus.rsp_valid1, id);
        check({tag, "_rsp_data"}, id ? bus.rsp_data1 : bus.rsp_data0, exp);
        check({tag, "_rsp_zero"}, id ? bus.rsp_zero1 : bus.rsp_zero0, exp == 32'd0);
        check({tag, "_other_data"}, id ? bus.rsp_data0 : bus.rsp_data1, 32'd0);
        tick();
        check({tag, "_idle_busy"}, bus.busy, 1'b0);
        check({tag, "_idle_novalid"}, bus.rsp_valid0 | bus.rsp_valid1, 1'b0);
        bus.rsp_ready0 = 1'b0;
        bus.rsp_ready1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          last_g;
        bit          exp_g;
        int          waited;
        bit          pend;
        bit          pend_id;
        int          pend_age;
        logic [31:0] pend_val;
        logic        v0, v1, rr0, rr1;
        logic [3:0]  c0, c1;
        logic [31:0] a0, a1, b0, b1;
        logic        e_rdy0, e_rdy1, e_rv0, e_rv1;
        logic [31:0] e_d0, e_d1;

        // Reset state, with a request already pending to prove req_ready is gated.
        clear_inputs();
        rstn = 1'b0;
        set_req(1'b0, 1'b1, 4'd2, 32'd5, 32'd7);
        #1;
        check("rst_ready0", bus.req_ready0, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_rsp_valid", bus.rsp_valid0 | bus.rsp_valid1, 1'b0);
        check("rst_rsp_data0", bus.rsp_data0, 32'd0);
        check("rst_alu_a", bus.alu_a, 32'd0);
        clear_inputs();
        tick();
        rstn = 1'b1;
        tick();

        // Single op: 5 + 7.
        run_op("single", 1'b0, 4'd2, 32'd5, 32'd7, 32'd12);

        // Contention from a fresh reset.
        do_reset();
        set_req(1'b0, 1'b1, 4'd6, 32'd3, 32'd3);
        set_req(1'b1, 1'b1, 4'd0, 32'h0000_00F0, 32'h0000_000F);
        bus.rsp_ready0 = 1'b1;
        bus.rsp_ready1 = 1'b1;
        #1;
        last_g = 1'b1;
        for (int op = 0; op < 4; op++) begin
            waited = 0;
            while (!(bus.req_ready0 || bus.req_ready1) && waited < 6) begin
                tick();
                waited++;
            end
            exp_g  = RR ? !last_g : 1'b0;
            last_g = exp_g;
            check("cont_grant0", bus.req_ready0, !exp_g);
            check("cont_grant1", bus.req_ready1, exp_g);
            tick();
            tick();
            check("cont_rsp_valid0", bus.rsp_valid0, !exp_g);
            check("cont_rsp_valid1", bus.rsp_valid1, exp_g);
            check("cont_rsp_data", exp_g ? bus.rsp_data1 : bus.rsp_data0, 32'd0);
            check("cont_rsp_zero", exp_g ? bus.rsp_zero1 : bus.rsp_zero0, 1'b1);
            tick();
        end
        clear_inputs();
        tick();

        // Backpressure on requester 1 while requester 0 waits.
        set_req(1'b1, 1'b1, 4'd1, 32'd1, 32'd2);
        #1;
        check("bp_ready1", bus.req_ready1, 1'b1);
        tick();
        set_req(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
        set_req(1'b0, 1'b1, 4'd2, 32'd7, 32'd7);
        #1;
        check("bp_exec_ready0", bus.req_ready0, 1'b0);
        tick();
        for (int i = 0; i < 10; i++) begin
            check("bp_rsp_valid1", bus.rsp_valid1, 1'b1);
            check("bp_rsp_data1", bus.rsp_data1, 32'd3);
            check("bp_ready0", bus.req_ready0, 1'b0);
            check("bp_busy", bus.busy, 1'b1);
            check("bp_rsp_valid0", bus.rsp_valid0, 1'b0);
            tick();
        end
        bus.rsp_ready1 = 1'b1;
        tick();
        bus.rsp_ready1 = 1'b0;
        check("bp_release_ready0", bus.req_ready0, 1'b1);
        bus.rsp_ready0 = 1'b1;
        tick();
        set_req(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        tick();
        check("bp_w0_valid", bus.rsp_valid0, 1'b1);
        check("bp_w0_data", bus.rsp_data0, 32'd14);
        tick();
        clear_inputs();

        // Reset while in EXEC aborts the op.
        set_req(1'b0, 1'b1, 4'd2, 32'd9, 32'd9);
        bus.rsp_ready0 = 1'b1;
        #1;
        check("rexec_ready0", bus.req_ready0, 1'b1);
        tick();
        set_req(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        rstn = 1'b0;
        #1;
        check("rexec_busy", bus.busy, 1'b0);
        check("rexec_rsp_valid", bus.rsp_valid0 | bus.rsp_valid1, 1'b0);
        check("rexec_alu_ctl", bus.alu_ctl, 4'd0);
        check("rexec_alu_a", bus.alu_a, 32'd0);
        check("rexec_alu_b", bus.alu_b, 32'd0);
        tick();
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rexec_no_rsp", bus.rsp_valid0 | bus.busy, 1'b0);
        end
        run_op("post_rst", 1'b0, 4'd2, 32'd1, 32'd1, 32'd2);

        // Shifts through the arbiter.
        run_op("sll", 1'b1, 4'd4, 32'd4, 32'd1, 32'h0000_0010);
        run_op("lui", 1'b0, 4'd10, 32'd0, 32'h0000_1234, 32'h1234_0000);
        run_op("badctl", 1'b1, 4'd15, 32'h0000_0100, 32'd0, 32'h5A5A_010F);

        // Randomized traffic against a transaction-level model.
        do_reset();
        last_g = 1'b1;
        pend   = 1'b0;
        pend_id = 1'b0;
        pend_age = 0;
        pend_val = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            v0 = ($urandom_range(0, 99) < 55);
            v1 = ($urandom_range(0, 99) < 55);
            c0 = 4'($urandom_range(0, 15));
            c1 = 4'($urandom_range(0, 15));
            a0 = $urandom; b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
            a1 = $urandom; b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
            rr0 = ($urandom_range(0, 99) < 70);
            rr1 = ($urandom_range(0, 99) < 70);
            set_req(1'b0, v0, c0, a0, b0);
            set_req(1'b1, v1, c1, a1, b1);
            bus.rsp_ready0 = rr0;
            bus.rsp_ready1 = rr1;
            #1;

            e_rdy0 = 1'b0; e_rdy1 = 1'b0; e_rv0 = 1'b0; e_rv1 = 1'b0;
            e_d0 = '0; e_d1 = '0;
            exp_g = 1'b0;
            if (!pend && (v0 || v1)) begin
                exp_g = (v0 && v1) ? (RR ? !last_g : 1'b0) : v1;
                if (exp_g) e_rdy1 = 1'b1; else e_rdy0 = 1'b1;
            end else if (pend && pend_age >= 1) begin
                if (pend_id) begin e_rv1 = 1'b1; e_d1 = pend_val; end
                else begin e_rv0 = 1'b1; e_d0 = pend_val; end
            end
            check("rnd_ready0", bus.req_ready0, e_rdy0);
            check("rnd_ready1", bus.req_ready1, e_rdy1);
            check("rnd_valid0", bus.rsp_valid0, e_rv0);
            check("rnd_valid1", bus.rsp_valid1, e_rv1);
            check("rnd_data0", bus.rsp_data0, e_d0);
            check("rnd_data1", bus.rsp_data1, e_d1);
            check("rnd_zero0", bus.rsp_zero0, e_rv0 && (e_d0 == 32'd0));
            check("rnd_zero1", bus.rsp_zero1, e_rv1 && (e_d1 == 32'd0));
            check("rnd_busy", bus.busy, pend);

            if (!pend && (v0 || v1)) begin
                pend     = 1'b1;
                pend_id  = exp_g;
                pend_age = 0;
                pend_val = exp_g ? alu_ref(c1, a1, b1) : alu_ref(c0, a0, b0);
                last_g   = exp_g;
            end else if (pend && pend_age == 0) begin
                pend_age = 1;
            end else if (pend && (pend_id ? rr1 : rr0)) begin
                pend = 1'b0;
            end
            tick();
        end
        clear_inputs();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
